vr_wheel_gen: RTL and testbench
===============================

VR_WHEEL_GEN -- requirements
Module: vr_wheel_gen

Interface
REQ-001 SHALL have parameter PERIOD_WIDTH, default 16, width of the tooth-period configuration and slot counter.
REQ-002 SHALL have parameter TEETH_WIDTH, default 8, width of the teeth-count configuration and tooth index.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ena  input  1  generator enable; high runs, low aborts.
REQ-006 SHALL have port tooth_period  input  PERIOD_WIDTH  slot length P in clocks.
REQ-007 SHALL have port teeth_total  input  TEETH_WIDTH  slots per revolution N.
REQ-008 SHALL have port teeth_missing  input  TEETH_WIDTH  missing-tooth count M (gap length).
REQ-009 SHALL have port vr_out  output  1  synthetic crank signal, a toothed wheel with a gap.
REQ-010 SHALL have port tooth_num  output  TEETH_WIDTH  index of the current slot, 0..N-1.
REQ-011 SHALL have port gap  output  1  high during missing-tooth slots.
REQ-012 SHALL have port rev_strobe  output  1  one-cycle pulse at the start of slot 0.
REQ-013 SHALL have port cfg_err  output  1  high while a rejected configuration is held.

Function
REQ-014 SHALL register all outputs; no combinational path from inputs to outputs.
REQ-015 SHALL implement FSM states IDLE, HIGH, LOW, GAP, ERR.
REQ-016 SHALL sample P, N and M into internal registers only on entry to slot 0 (IDLE exit and each revolution wrap); changes mid-revolution take effect at the next slot 0.
REQ-017 SHALL treat a configuration as valid when P>=2, N>=2 and M<N.
REQ-018 SHALL, in IDLE with ena=1 and a valid config, go to HIGH at the sampling edge with tooth_num=0, vr_out=1, gap=0, rev_strobe=1.
REQ-019 SHALL, in IDLE with ena=1 and an invalid config, go to ERR with cfg_err=1 and vr_out=0.
REQ-020 SHALL, in ERR, return to IDLE at the first edge where ena=0 or the config is valid; from ERR, a valid config with ena=1 passes through IDLE for one cycle.
REQ-021 SHALL hold HIGH for H=floor(P/2) clocks with vr_out=1, then LOW for P-H clocks with vr_out=0, for a total slot length of exactly P clocks.
REQ-022 SHALL treat slots 0..N-M-1 as real teeth (HIGH then LOW) and slots N-M..N-1 as GAP slots, with vr_out=0 and gap=1 for P clocks each.
REQ-023 SHALL increment tooth_num at each slot boundary and wrap N-1 to 0, re-sampling the config at the wrap (REQ-016).
REQ-024 SHALL make the total revolution length exactly N*P clocks, with rev_strobe pulsing once every N*P clocks.
REQ-025 SHALL pulse rev_strobe for exactly one cycle, coincident with the first cycle of slot 0; it is never asserted in any other cycle.
REQ-026 SHALL, when the config re-sampled at the wrap is invalid, go to ERR instead of slot 0 and SHALL NOT pulse rev_strobe.
REQ-027 SHALL, when ena=0 is sampled in HIGH, LOW or GAP, go to IDLE at that edge with all outputs at their reset values, without completing the slot.
REQ-028 SHALL treat M=0 as a wheel with no gap: gap stays 0 and every slot is a real tooth.
REQ-029 SHALL use internal slot counters wide enough for P clocks and SHALL NOT overflow for P = 2^PERIOD_WIDTH-1.

Reset
REQ-030 SHALL, on rst=0 at any time, including mid-slot, immediately force state IDLE, vr_out=0, tooth_num=0, gap=0, rev_strobe=0, cfg_err=0 and clear the internal counters and config registers.
REQ-031 SHALL, after rst returns high, start only by the IDLE rule in REQ-018, and no earlier than the first edge with rst=1.

Verification
REQ-032 SHALL cover: P=10, N=6, M=2, ena=1 -> vr_out 5 high/5 low for teeth 0..3, then 20 clocks low with gap=1 for tooth_num 4..5; rev_strobe every 60 clocks.
REQ-033 SHALL cover: P=7, N=4, M=0 -> each slot 3 high/4 low, gap never asserted, rev_strobe period 28.
REQ-034 SHALL cover: P changed from 10 to 20 at tooth 2 -> remainder of the revolution still uses 10-clock slots; the next revolution uses 20-clock slots.
REQ-035 SHALL cover: M=6 with N=6, or P=1 -> cfg_err=1, vr_out=0; correcting the config returns the block to IDLE, then it starts with rev_strobe.
REQ-036 SHALL cover: ena dropped mid HIGH at tooth 3 -> next edge IDLE with all outputs zero; re-enabling restarts at tooth 0 with rev_strobe.
REQ-037 SHALL cover: rst asserted mid GAP -> outputs zero immediately, without waiting for a clock; after release with ena=1, the first edge gives HIGH with tooth 0.

Source files
------------

// File: rtl/vr_wheel_gen.sv
// Synthetic variable-reluctance crank wheel: N slots of P clocks each, the last M
// slots forming the missing-tooth gap. Config is latched at every slot-0 entry.
module vr_wheel_gen #(
   parameter int PERIOD_WIDTH = 16,
   parameter int TEETH_WIDTH  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ena,
   input  logic [PERIOD_WIDTH-1:0] tooth_period,
   input  logic [TEETH_WIDTH-1:0]  teeth_total,
   input  logic [TEETH_WIDTH-1:0]  teeth_missing,
   output logic                    vr_out,
   output logic [TEETH_WIDTH-1:0]  tooth_num,
   output logic                    gap,
   output logic                    rev_strobe,
   output logic                    cfg_err
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HIGH,
      ST_LOW,
      ST_GAP,
      ST_ERR
   } state_e;

   state_e                  state_q, state_d;
   logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
   logic [TEETH_WIDTH-1:0]  tooth_q, tooth_d;
   logic [PERIOD_WIDTH-1:0] per_q, per_d;
   logic [TEETH_WIDTH-1:0]  tot_q, tot_d;
   logic [TEETH_WIDTH-1:0]  miss_q, miss_d;
   logic                    vr_q, vr_d;
   logic                    gap_q, gap_d;
   logic                    rev_q, rev_d;
   logic                    err_q, err_d;

   logic                    cfg_ok;
   logic [PERIOD_WIDTH-1:0] half;
   logic                    high_end;
   logic                    slot_end;
   logic                    last_tooth;
   logic [TEETH_WIDTH-1:0]  tooth_inc;
   logic                    enter_slot0;
   logic                    enter_err;
   logic                    go_idle;

   assign cfg_ok     = (tooth_period >= PERIOD_WIDTH'(2)) &&
                       (teeth_total >= TEETH_WIDTH'(2)) &&
                       (teeth_missing < teeth_total);
   assign half       = per_q >> 1;
   assign high_end   = (cnt_q == half - PERIOD_WIDTH'(1));
   assign slot_end   = (cnt_q == per_q - PERIOD_WIDTH'(1));
   assign last_tooth = (tooth_q == tot_q - TEETH_WIDTH'(1));
   assign tooth_inc  = tooth_q + TEETH_WIDTH'(1);

   // NOTE: every always_comb target gets a default first, otherwise a path that
   // skips an assignment infers a latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tooth_d     = tooth_q;
      per_d       = per_q;
      tot_d       = tot_q;
      miss_d      = miss_q;
      vr_d        = vr_q;
      gap_d       = gap_q;
      rev_d       = 1'b0;
      err_d       = err_q;
      enter_slot0 = 1'b0;
      enter_err   = 1'b0;
      go_idle     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (ena) begin
               if (cfg_ok) enter_slot0 = 1'b1;
               else        enter_err   = 1'b1;
            end
         end
         ST_HIGH: begin
            if (!ena) begin
               go_idle = 1'b1;
            end else begin
               cnt_d = cnt_q + PERIOD_WIDTH'(1);
               if (high_end) begin
                  state_d = ST_LOW;
                  vr_d    = 1'b0;
               end
            end
         end
         ST_LOW, ST_GAP: begin
            if (!ena) begin
               go_idle = 1'b1;
            end else if (!slot_end) begin
               cnt_d = cnt_q + PERIOD_WIDTH'(1);
            end else if (last_tooth) begin
               // Revolution wrap: re-validate whatever config is presented now.
               if (cfg_ok) enter_slot0 = 1'b1;
               else        enter_err   = 1'b1;
            end else begin
               cnt_d   = '0;
               tooth_d = tooth_inc;
               if (tooth_inc >= tot_q - miss_q) begin
                  state_d = ST_GAP;
                  vr_d    = 1'b0;
                  gap_d   = 1'b1;
               end else begin
                  state_d = ST_HIGH;
                  vr_d    = 1'b1;
                  gap_d   = 1'b0;
               end
            end
         end
         ST_ERR: begin
            if (!ena || cfg_ok) go_idle = 1'b1;
         end
         default: go_idle = 1'b1;
      endcase

      if (go_idle) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         tooth_d = '0;
         vr_d    = 1'b0;
         gap_d   = 1'b0;
         err_d   = 1'b0;
      end

      if (enter_slot0) begin
         state_d = ST_HIGH;
         cnt_d   = '0;
         tooth_d = '0;
         per_d   = tooth_period;
         tot_d   = teeth_total;
         miss_d  = teeth_missing;
         vr_d    = 1'b1;
         gap_d   = 1'b0;
         rev_d   = 1'b1;
         err_d   = 1'b0;
      end

      if (enter_err) begin
         state_d = ST_ERR;
         cnt_d   = '0;
         tooth_d = '0;
         vr_d    = 1'b0;
         gap_d   = 1'b0;
         err_d   = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the config registers are plain flops, not a memory, so they are
         // cleared with everything else for a fully known post-reset state.
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         tooth_q <= '0;
         per_q   <= '0;
         tot_q   <= '0;
         miss_q  <= '0;
         vr_q    <= 1'b0;
         gap_q   <= 1'b0;
         rev_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tooth_q <= tooth_d;
         per_q   <= per_d;
         tot_q   <= tot_d;
         miss_q  <= miss_d;
         vr_q    <= vr_d;
         gap_q   <= gap_d;
         rev_q   <= rev_d;
         err_q   <= err_d;
      end
   end

   assign vr_out     = vr_q;
   assign tooth_num  = tooth_q;
   assign gap        = gap_q;
   assign rev_strobe = rev_q;
   assign cfg_err    = err_q;

endmodule

// File: tb/tb_vr_wheel_gen.sv
// Scoreboard bench for vr_wheel_gen: a revolution-time model predicts every
// cycle's outputs; a monitor pops and compares them one cycle at a time.
module tb_vr_wheel_gen;

   localparam int PW = 16;
   localparam int TW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ena = 1'b0;
   logic [PW-1:0] tooth_period = '0;
   logic [TW-1:0] teeth_total = '0;
   logic [TW-1:0] teeth_missing = '0;
   logic          vr_out;
   logic [TW-1:0] tooth_num;
   logic          gap;
   logic          rev_strobe;
   logic          cfg_err;

   vr_wheel_gen #(.PERIOD_WIDTH(PW), .TEETH_WIDTH(TW)) dut (
      .clk           (clk),
      .rst           (rst),
      .ena           (ena),
      .tooth_period  (tooth_period),
      .teeth_total   (teeth_total),
      .teeth_missing (teeth_missing),
      .vr_out        (vr_out),
      .tooth_num     (tooth_num),
      .gap           (gap),
      .rev_strobe    (rev_strobe),
      .cfg_err       (cfg_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          vr;
      logic [TW-1:0] tooth;
      logic          gp;
      logic          rev;
      logic          err;
   } obs_t;

   obs_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: mode plus elapsed clocks since the start of slot 0.
   typedef enum int {M_IDLE, M_RUN, M_ERR} mode_e;
   mode_e md_mode = M_IDLE;
   int    md_t = 0, md_p = 0, md_n = 0, md_m = 0;

   function automatic string fmt(obs_t o);
      return $sformatf("vr=%0b tooth=%0d gap=%0b rev=%0b err=%0b",
                       o.vr, o.tooth, o.gp, o.rev, o.err);
   endfunction

   function automatic obs_t dut_obs();
      return obs_t'{vr_out, tooth_num, gap, rev_strobe, cfg_err};
   endfunction

   task automatic check(string name, obs_t act, obs_t exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %s, expected %s", name, $time, fmt(act), fmt(exp));
      end
   endtask

   function automatic bit cfg_valid(int p, int n, int m);
      return (p >= 2) && (n >= 2) && (m < n);
   endfunction

   function automatic obs_t model_out();
      obs_t o;
      int   slot, off;
      o = '0;
      if (md_mode == M_ERR) begin
         o.err = 1'b1;
      end else if (md_mode == M_RUN) begin
         slot    = md_t / md_p;
         off     = md_t % md_p;
         o.tooth = TW'(slot);
         o.gp    = (slot >= md_n - md_m);
         o.vr    = (slot < md_n - md_m) && (off < md_p / 2);
         o.rev   = (md_t == 0);
      end
      return o;
   endfunction

   task automatic model_edge(bit r, bit e, int p, int n, int m);
      if (!r) begin
         md_mode = M_IDLE;
         return;
      end
      case (md_mode)
         M_IDLE: if (e) begin
            if (cfg_valid(p, n, m)) begin
               md_mode = M_RUN; md_t = 0; md_p = p; md_n = n; md_m = m;
            end else begin
               md_mode = M_ERR;
            end
         end
         M_RUN: if (!e) begin
            md_mode = M_IDLE;
         end else begin
            md_t++;
            if (md_t == md_n * md_p) begin
               if (cfg_valid(p, n, m)) begin
                  md_t = 0; md_p = p; md_n = n; md_m = m;
               end else begin
                  md_mode = M_ERR;
               end
            end
         end
         default: if (!e || cfg_valid(p, n, m)) md_mode = M_IDLE;
      endcase
   endtask

   task automatic step(bit e, int p, int n, int m);
      @(negedge clk);
      rst           = 1'b1;
      ena           = e;
      tooth_period  = PW'(p);
      teeth_total   = TW'(n);
      teeth_missing = TW'(m);
      model_edge(1'b1, e, p, n, m);
      exp_q.push_back(model_out());
   endtask

   task automatic run(int cycles, bit e, int p, int n, int m);
      for (int i = 0; i < cycles; i++) step(e, p, n, m);
   endtask

   initial begin : monitor
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) check("out_cycle", dut_obs(), exp_q.pop_front());
      end
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int p, n, m, guard;
      bit e;

      #2 rst = 1'b0;
      #1 check("reset_state", dut_obs(), obs_t'('0));
      repeat (2) @(posedge clk);

      // 10-clock slots, 6 teeth, 2 missing: 5/5 teeth then 20-clock gap.
      run(130, 1, 10, 6, 2);

      // No-gap wheel, odd period.
      step(0, 7, 4, 0);
      run(70, 1, 7, 4, 0);

      // Period change mid-revolution only takes effect at the next slot 0.
      step(0, 10, 6, 2);
      run(25, 1, 10, 6, 2);
      run(160, 1, 20, 6, 2);

      // Rejected configs, then correction via IDLE.
      step(0, 10, 6, 2);
      run(4, 1, 10, 6, 6);
      run(15, 1, 10, 6, 2);
      step(0, 10, 6, 2);
      run(4, 1, 1, 6, 2);
      run(15, 1, 10, 6, 2);

      // Enable dropped mid-HIGH on tooth 3, then restart.
      step(0, 10, 6, 2);
      run(32, 1, 10, 6, 2);
      step(0, 10, 6, 2);
      run(20, 1, 10, 6, 2);

      // Config made invalid mid-revolution: ERR at the wrap, no strobe.
      step(0, 4, 3, 1);
      run(5, 1, 4, 3, 1);
      run(16, 1, 4, 3, 3);
      run(20, 1, 4, 3, 1);

      // Asynchronous reset in the middle of a gap slot.
      step(0, 6, 5, 2);
      run(20, 1, 6, 5, 2);
      guard = 0;
      while (!(md_mode == M_RUN && md_t / md_p >= md_n - md_m) && guard < 100) begin
         step(1, 6, 5, 2);
         guard++;
      end
      run(2, 1, 6, 5, 2);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 check("rst_async", dut_obs(), obs_t'('0));
      model_edge(1'b0, 1'b1, 6, 5, 2);
      exp_q.push_back(model_out());
      run(40, 1, 6, 5, 2);

      // Randomized configs, enable drops and mid-revolution period changes.
      for (int k = 0; k < 12; k++) begin
         p = ($urandom_range(0, 9) == 0) ? 1 : int'($urandom_range(2, 12));
         n = $urandom_range(2, 8);
         m = $urandom_range(0, n);
         for (int c = 0; c < 150; c++) begin
            e = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 29) == 0) p = $urandom_range(1, 12);
            if ($urandom_range(0, 59) == 0) m = $urandom_range(0, n);
            step(e, p, n, m);
         end
      end

      // Widest period: half-slot counter must reach 32766 and wrap cleanly.
      step(0, 65535, 2, 1);
      run(32800, 1, 65535, 2, 1);

      @(posedge clk);
      #2;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
